// File: rtl/euler_accumulator_if.sv
// Increment input stream and updated-state output stream of the Euler accumulator.
// The master drives increments and output backpressure; the slave is the accumulator.
interface euler_accumulator_if #(
    parameter int unsigned WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             in_sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;

    modport master (
        output in_valid,
        output in_data,
        output in_sub,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_data
    );

    modport slave (
        input  in_valid,
        input  in_data,
        input  in_sub,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_data
    );
endinterface

// File: rtl/euler_accumulator.sv
// Euler accumulation stage: y <= y +/- h*f through one add_sub_cs, with saturation,
// sticky overflow, valid/ready output and a done pulse. add_sub_cs is defined here too.
module add_sub_cs (
    input  logic [15:0] in1_i,
    input  logic [15:0] in2_i,
    input  logic        sub_i,
    input  logic        cin_i,
    output logic [15:0] out_o,
    output logic        cout_o,
    output logic        invalid_o
);
    logic [15:0] op_b;
    logic        carry_in;
    logic [15:0] low_sum;
    logic [16:0] full_sum;

    always_comb begin
        op_b      = sub_i ? ~in2_i : in2_i;
        carry_in  = sub_i | cin_i;
        low_sum   = {1'b0, in1_i[14:0]} + {1'b0, op_b[14:0]} + {15'd0, carry_in};
        full_sum  = {1'b0, in1_i} + {1'b0, op_b} + {16'd0, carry_in};
        out_o     = full_sum[15:0];
        cout_o    = full_sum[16];
        // Signed overflow: carry into the sign bit differs from carry out of it.
        invalid_o = low_sum[15] ^ full_sum[16];
    end
endmodule

module euler_accumulator #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start_i,
    input  logic [WIDTH-1:0]     y0_i,
    input  logic [CNT_W-1:0]     n_steps_i,
    euler_accumulator_if.slave   bus_io,
    output logic [CNT_W-1:0]     step_count_o,
    output logic                 busy_o,
    output logic                 done_o,
    output logic                 overflow_o
);
    typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;

    localparam logic [WIDTH-1:0] SatPos = {1'b0, {(WIDTH - 1){1'b1}}};
    localparam logic [WIDTH-1:0] SatNeg = {1'b1, {(WIDTH - 1){1'b0}}};

    state_e           state_q;
    logic [WIDTH-1:0] acc_q;
    logic [CNT_W-1:0] n_q;
    logic [CNT_W-1:0] step_q;
    logic [WIDTH-1:0] out_data_q;
    logic             out_valid_q;
    logic             overflow_q;
    logic             busy_q;
    logic             done_q;

    logic [WIDTH-1:0] add_out;
    logic             add_invalid;
    logic             add_cout_unused;
    logic [WIDTH-1:0] step_val;
    logic [CNT_W-1:0] step_next;
    logic             in_ready;
    logic             accept;

    add_sub_cs u_add_sub (
        .in1_i     (acc_q),
        .in2_i     (bus_io.in_data),
        .sub_i     (bus_io.in_sub),
        .cin_i     (1'b0),
        .out_o     (add_out),
        .cout_o    (add_cout_unused),
        .invalid_o (add_invalid)
    );

    always_comb begin
        in_ready  = (state_q == StRun) && (step_q < n_q) && (!out_valid_q || bus_io.out_ready);
        accept    = in_ready && bus_io.in_valid;
        step_next = step_q + CNT_W'(1);
        // Saturate toward the sign of the pre-step state.
        step_val  = add_invalid ? (acc_q[WIDTH-1] ? SatNeg : SatPos) : add_out;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            acc_q       <= '0;
            n_q         <= '0;
            step_q      <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            overflow_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (bus_io.out_ready) begin
                out_valid_q <= 1'b0;
            end
            unique case (state_q)
                StIdle: begin
                    if (start_i) begin
                        acc_q      <= y0_i;
                        n_q        <= n_steps_i;
                        step_q     <= '0;
                        overflow_q <= 1'b0;
                        if (n_steps_i == '0) begin
                            state_q <= StDone;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= StRun;
                            busy_q  <= 1'b1;
                        end
                    end
                end
                StRun: begin
                    if (accept) begin
                        acc_q       <= step_val;
                        out_data_q  <= step_val;
                        out_valid_q <= 1'b1;
                        step_q      <= step_next;
                        overflow_q  <= overflow_q | add_invalid;
                        if (step_next == n_q) begin
                            state_q <= StDrain;
                        end
                    end
                end
                StDrain: begin
                    if (!out_valid_q || bus_io.out_ready) begin
                        state_q <= StDone;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
                StDone: begin
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus_io.in_ready  = in_ready;
    assign bus_io.out_valid = out_valid_q;
    assign bus_io.out_data  = out_data_q;
    assign step_count_o     = step_q;
    assign busy_o           = busy_q;
    assign done_o           = done_q;
    assign overflow_o       = overflow_q;
endmodule

// File: tb/tb_euler_accumulator.sv
// Directed bench for euler_accumulator: basic run, saturation, backpressure,
// zero steps, ignored start and asynchronous reset mid-run.
module tb_euler_accumulator;
    logic        clk;
    logic        rst;
    logic        start;
    logic [15:0] y0;
    logic [15:0] n_steps;
    logic [15:0] step_count;
    logic        busy;
    logic        done;
    logic        overflow;

    int n_checks = 0;
    int n_errors = 0;

    euler_accumulator_if #(.WIDTH(16)) bus ();

    euler_accumulator #(
        .WIDTH (16),
        .CNT_W (16)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start_i      (start),
        .y0_i         (y0),
        .n_steps_i    (n_steps),
        .bus_io       (bus),
        .step_count_o (step_count),
        .busy_o       (busy),
        .done_o       (done),
        .overflow_o   (overflow)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d",
                 n_errors, n_checks);
        $fatal(1);
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset(input string tag);
        check_eq({tag, "_in_ready"}, bus.in_ready, 0);
        check_eq({tag, "_out_valid"}, bus.out_valid, 0);
        check_eq({tag, "_out_data"}, bus.out_data, 0);
        check_eq({tag, "_step_count"}, step_count, 0);
        check_eq({tag, "_busy"}, busy, 0);
        check_eq({tag, "_done"}, done, 0);
        check_eq({tag, "_overflow"}, overflow, 0);
    endtask

    task automatic wait_done(input string tag);
        bit seen = 1'b0;
        for (int i = 0; i < 8 && !seen; i++) begin
            tick();
            if (done === 1'b1) seen = 1'b1;
        end
        check_eq({tag, "_done_seen"}, seen, 1);
    endtask

    // y0=2, +3, +3, -1 -> 5, 8, 7
    task automatic run_basic(input string tag);
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_sub    = 1'b0;
        start = 1'b1; y0 = 16'd2; n_steps = 16'd3;
        tick();
        start = 1'b0;
        #1;
        check_eq({tag, "_busy"}, busy, 1);
        check_eq({tag, "_in_ready"}, bus.in_ready, 1);
        bus.in_valid = 1'b1; bus.in_data = 16'd3;
        tick();
        check_eq({tag, "_out_valid1"}, bus.out_valid, 1);
        check_eq({tag, "_out1"}, bus.out_data, 16'd5);
        tick();
        check_eq({tag, "_out2"}, bus.out_data, 16'd8);
        bus.in_sub = 1'b1; bus.in_data = 16'd1;
        tick();
        check_eq({tag, "_out3"}, bus.out_data, 16'd7);
        check_eq({tag, "_steps"}, step_count, 16'd3);
        bus.in_valid = 1'b0; bus.in_sub = 1'b0;
        #1;
        check_eq({tag, "_drain_in_ready"}, bus.in_ready, 0);
        check_eq({tag, "_no_early_done"}, done, 0);
        tick();
        check_eq({tag, "_done"}, done, 1);
        check_eq({tag, "_busy_done"}, busy, 0);
        tick();
        check_eq({tag, "_done_pulse"}, done, 0);
        check_eq({tag, "_hold_out"}, bus.out_data, 16'd7);
        check_eq({tag, "_overflow"}, overflow, 0);
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0; y0 = '0; n_steps = '0;
        bus.in_valid = 1'b0; bus.in_data = '0; bus.in_sub = 1'b0; bus.out_ready = 1'b1;
        #12;
        check_reset("reset");
        rst = 1'b0;
        tick();

        run_basic("basic");

        // Positive saturation, then overflow cleared by a zero-step start.
        start = 1'b1; y0 = 16'h7FF0; n_steps = 16'd1;
        tick();
        start = 1'b0;
        bus.in_valid = 1'b1; bus.in_data = 16'h0020; bus.in_sub = 1'b0;
        tick();
        bus.in_valid = 1'b0;
        check_eq("pos_sat_out", bus.out_data, 16'h7FFF);
        check_eq("pos_sat_ovf", overflow, 1);
        wait_done("pos_sat");
        tick();
        start = 1'b1; y0 = 16'd0; n_steps = 16'd0;
        tick();
        start = 1'b0;
        check_eq("ovf_cleared", overflow, 0);
        check_eq("zero_done_a", done, 1);
        tick();

        // Negative saturation through subtract.
        start = 1'b1; y0 = 16'h8005; n_steps = 16'd1;
        tick();
        start = 1'b0;
        bus.in_valid = 1'b1; bus.in_data = 16'h0010; bus.in_sub = 1'b1;
        tick();
        bus.in_valid = 1'b0; bus.in_sub = 1'b0;
        check_eq("neg_sat_out", bus.out_data, 16'h8000);
        check_eq("neg_sat_ovf", overflow, 1);
        wait_done("neg_sat");
        tick();

        // Backpressure: 100 +10 (stall 3) +20 -5 +7 -> 110, 130, 125, 132
        start = 1'b1; y0 = 16'd100; n_steps = 16'd4;
        tick();
        start = 1'b0;
        bus.in_valid = 1'b1; bus.in_data = 16'd10;
        tick();
        check_eq("bp_out1", bus.out_data, 16'd110);
        bus.out_ready = 1'b0; bus.in_data = 16'd20;
        for (int i = 0; i < 3; i++) begin
            #1;
            check_eq("bp_stall_in_ready", bus.in_ready, 0);
            check_eq("bp_stall_data", bus.out_data, 16'd110);
            check_eq("bp_stall_valid", bus.out_valid, 1);
            tick();
        end
        bus.out_ready = 1'b1;
        #1;
        check_eq("bp_resume_in_ready", bus.in_ready, 1);
        tick();
        check_eq("bp_out2", bus.out_data, 16'd130);
        bus.in_sub = 1'b1; bus.in_data = 16'd5;
        tick();
        check_eq("bp_out3", bus.out_data, 16'd125);
        bus.in_sub = 1'b0; bus.in_data = 16'd7;
        tick();
        bus.in_valid = 1'b0;
        check_eq("bp_out4", bus.out_data, 16'd132);
        check_eq("bp_steps", step_count, 16'd4);
        wait_done("bp");
        tick();

        // Zero steps: done next cycle, no output.
        start = 1'b1; y0 = 16'd9; n_steps = 16'd0;
        tick();
        start = 1'b0;
        check_eq("zero_done", done, 1);
        check_eq("zero_busy", busy, 0);
        check_eq("zero_out_valid", bus.out_valid, 0);
        tick();
        check_eq("zero_done_pulse", done, 0);
        check_eq("zero_out_valid2", bus.out_valid, 0);

        // start during RUN is ignored.
        start = 1'b1; y0 = 16'd1; n_steps = 16'd2;
        tick();
        y0 = 16'd50; n_steps = 16'd9;
        bus.in_valid = 1'b1; bus.in_data = 16'd1;
        tick();
        start = 1'b0;
        check_eq("ign_start_out1", bus.out_data, 16'd2);
        tick();
        bus.in_valid = 1'b0;
        check_eq("ign_start_out2", bus.out_data, 16'd3);
        wait_done("ign_start");
        check_eq("ign_start_steps", step_count, 16'd2);
        tick();

        // Reset mid-run after the second of four increments.
        start = 1'b1; y0 = 16'd0; n_steps = 16'd4;
        tick();
        start = 1'b0;
        bus.in_valid = 1'b1; bus.in_data = 16'd1;
        tick();
        tick();
        check_eq("rst_pre_out", bus.out_data, 16'd2);
        check_eq("rst_pre_steps", step_count, 16'd2);
        #2;
        rst = 1'b1;
        #1;
        check_reset("rst_mid");
        bus.in_valid = 1'b0;
        tick();
        #3;
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_eq("rst_no_done", done, 0);
        end
        run_basic("after_rst");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
